// File: rtl/icache_fetch_responder.sv
// rtl/icache_fetch_responder.sv - direct-mapped instruction cache answering the fetch PC interface
// Arrays are indexed by the next PC; the tag and word are taken from the current PC.
module icache_fetch_responder #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 5,
  parameter int OFFSET_WIDTH = 2,
  parameter int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_pc_next,
  input  logic [ADDR_WIDTH-1:0] i_pc_current,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic                  o_valid,
  output logic                  o_miss_stall,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_req_ready,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int WORDS = 1 << OFFSET_WIDTH;
  localparam int LOW   = OFFSET_WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_WAIT} state_t;

  state_t                  state_q, state_d;
  logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
  logic [LINES-1:0]        valid_q, valid_d;

  logic [WORDS-1:0][DATA_WIDTH-1:0] data_mem [LINES];
  logic [TAG_WIDTH-1:0]             tag_mem  [LINES];
  logic [WORDS-1:0][DATA_WIDTH-1:0] rd_line_q;
  logic [TAG_WIDTH-1:0]             rd_tag_q;

  logic [INDEX_WIDTH-1:0]  idx_next, idx_cur;
  logic [TAG_WIDTH-1:0]    tag_cur;
  logic [OFFSET_WIDTH-1:0] word_cur;
  logic                    hit;
  logic                    beat_we;
  logic                    last_beat;
  logic                    unused_bits;

  assign idx_next  = i_pc_next[LOW +: INDEX_WIDTH];
  assign idx_cur   = i_pc_current[LOW +: INDEX_WIDTH];
  assign tag_cur   = i_pc_current[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign word_cur  = i_pc_current[2 +: OFFSET_WIDTH];
  assign hit       = valid_q[idx_cur] && (rd_tag_q == tag_cur);
  assign last_beat = (cnt_q == {OFFSET_WIDTH{1'b1}});
  assign unused_bits = ^{i_pc_next[ADDR_WIDTH-1:LOW+INDEX_WIDTH], i_pc_next[LOW-1:0],
                         i_pc_current[1:0]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    o_valid      = 1'b0;
    o_miss_stall = 1'b0;
    o_mem_req    = 1'b0;
    o_mem_addr   = '0;
    beat_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          o_valid = 1'b1;
        end else begin
          o_miss_stall = 1'b1;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        o_miss_stall = 1'b1;
        o_mem_req    = 1'b1;
        o_mem_addr   = {i_pc_current[ADDR_WIDTH-1:LOW], {LOW{1'b0}}};
        if (i_mem_req_ready) begin
          state_d = S_FILL;
          cnt_d   = '0;
        end
      end
      S_FILL: begin
        o_miss_stall = 1'b1;
        if (i_mem_rvalid) begin
          beat_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (last_beat) begin
            valid_d[idx_cur] = 1'b1;
            state_d          = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // The arrays re-read the freshly written line at the held index this cycle.
        o_miss_stall = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    o_instr = o_valid ? rd_line_q[word_cur] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // Synchronous arrays; a same-cycle write and read of one line returns the old contents.
  always_ff @(posedge clk) begin
    rd_line_q <= data_mem[idx_next];
    rd_tag_q  <= tag_mem[idx_next];
    if (beat_we && !rst) begin
      data_mem[idx_cur][cnt_q] <= i_mem_rdata;
      if (last_beat) tag_mem[idx_cur] <= tag_cur;
    end
  end

endmodule
